// File: rtl/sistema_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a one-shot pulse engine.
// Optional feature macro: SISTEMA_PIO_IRQ_EN (registered pulse-done interrupt with enable bit).
module sistema_pio_out_pulse #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] RESET_PLEN  = 32'h1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  plen_q, plen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              irq_en;

    logic              wr;
    logic              pulse_wr;
    logic              busy;
    logic [DATA_W-1:0] wd;
    logic [CNT_W-1:0]  plen_eff;
    logic              wd_unused;

    assign wr        = chipselect & ~write_n;
    assign pulse_wr  = wr && (address == 3'd5);
    assign wd        = writedata[DATA_W-1:0];
    assign plen_eff  = (plen_q == '0) ? CNT_W'(1) : plen_q;
    assign wd_unused = ^writedata;

`ifdef SISTEMA_PIO_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_q & irq_en_q;
        end
    end

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && address == 3'd6)
            irq_en_d = writedata[0];
    end

    assign irq_en = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= RESET_VALUE[DATA_W-1:0];
            mask_q  <= '0;
            plen_q  <= RESET_PLEN[CNT_W-1:0];
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: register writes and pulse FSM
    always_comb begin
        data_d  = data_q;
        plen_d  = plen_q;
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        if (wr) begin
            case (address)
                3'd0:    data_d = wd;
                3'd1:    data_d = data_q | wd;
                3'd2:    data_d = data_q & ~wd;
                3'd3:    data_d = data_q ^ wd;
                3'd4:    plen_d = writedata[CNT_W-1:0];
                3'd6:    if (writedata[1]) done_d = 1'b0;
                default: ;
            endcase
        end

        // Expiry is evaluated after the done-clear so that setting wins.
        if (pulse_wr) begin
            state_d = ACTIVE;
            mask_d  = wd;
            cnt_d   = plen_eff;
        end else if (state_q == ACTIVE) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        busy     = (state_q == ACTIVE);
        out_port = data_q ^ (busy ? mask_q : '0);
`ifdef SISTEMA_PIO_IRQ_EN
        irq      = irq_q;
`else
        irq      = 1'b0;
`endif
        readdata = '0;
        case (address)
            3'd0:    readdata[DATA_W-1:0] = data_q;
            3'd4:    readdata[CNT_W-1:0]  = plen_q;
            3'd5:    readdata[1:0]        = {done_q, busy};
            3'd6:    readdata[1:0]        = {done_q, irq_en};
            default: ;
        endcase
    end

endmodule
